// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: direction, target, misprediction redirect,
// jump link data, misaligned-target exception and branch counters.
`timescale 1ns/1ps
module branch_resolve #(
  parameter int CNT_W     = 32,
  parameter bit SUPPORT_C = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic             br_is_jal,
  input  logic             br_is_jalr,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic [31:0]      br_rs1,
  input  logic [2:0]       cmp_result,
  input  logic [2:0]       ucmp_result,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             link_valid,
  output logic [31:0]      link_data,
  output logic             exc_valid,
  output logic [31:0]      exc_tval,
  output logic             cmp_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state_q;
  logic        accept;
  logic        is_jump;
  logic        is_uns;
  logic [2:0]  code;
  logic        code_ok;
  logic        cond;
  logic        taken;
  logic        misal;
  logic        mispred;
  logic [31:0] sum;
  logic [31:0] target;
  logic [31:0] pc4;

  // Held low during the handshake cycle so no younger op slips in.
  assign br_ready = !rst && !redirect_valid && !flush;
  assign accept   = br_valid && br_ready;
  assign pc4      = br_pc + 32'd4;

  always_comb begin
    is_jump = br_is_jal | br_is_jalr;
    is_uns  = (br_funct3[2:1] == 2'b11);
    code    = is_uns ? ucmp_result : cmp_result;
    code_ok = $onehot(code);
    case (br_funct3)
      3'b000:         cond = code[1];
      3'b001:         cond = code[0] | code[2];
      3'b100, 3'b110: cond = code[0];
      3'b101, 3'b111: cond = code[1] | code[2];
      default:        cond = 1'b0;
    endcase
    taken   = is_jump | (code_ok & cond);
    sum     = (br_is_jalr ? br_rs1 : br_pc) + br_imm;
    target  = br_is_jalr ? {sum[31:1], 1'b0} : sum;
    misal   = taken && target[1] && !SUPPORT_C;
    mispred = !misal &&
              ((taken != pred_taken) ||
               (taken && (target != pred_target)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_valid     <= 1'b0;
      link_data      <= '0;
      exc_valid      <= 1'b0;
      exc_tval       <= '0;
      cmp_err        <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      link_valid <= accept && is_jump && !misal;
      exc_valid  <= accept && misal;
      cmp_err    <= accept && !is_jump && !code_ok;
      if (accept && is_jump) link_data <= pc4;
      if (accept && misal) exc_tval <= target;
      if (accept) branch_cnt <= branch_cnt + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          if (accept && mispred) begin
            state_q        <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= taken ? target : pc4;
            mispred_cnt    <= mispred_cnt + CNT_W'(1);
          end
        end
        REDIRECT: begin
          // Flush drops the redirect without waiting for fetch.
          if (flush || redirect_ready) begin
            state_q        <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve against a
// comparison-level reference model.
`timescale 1ns/1ps
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_funct3;
  logic        br_is_jal;
  logic        br_is_jalr;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] br_rs1;
  logic [2:0]  cmp_result;
  logic [2:0]  ucmp_result;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        link_valid;
  logic [31:0] link_data;
  logic        exc_valid;
  logic [31:0] exc_tval;
  logic        cmp_err;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  // operands behind the comparator codes
  logic [31:0] op_a, op_b;
  logic        force_code;
  logic [2:0]  fcode;

  // reference state
  logic        m_redir;
  logic [31:0] m_rpc, m_bcnt, m_mcnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst(rst), .flush(flush),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_is_jal(br_is_jal),
    .br_is_jalr(br_is_jalr), .br_pc(br_pc),
    .br_imm(br_imm), .br_rs1(br_rs1),
    .cmp_result(cmp_result), .ucmp_result(ucmp_result),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .link_valid(link_valid), .link_data(link_data),
    .exc_valid(exc_valid), .exc_tval(exc_tval),
    .cmp_err(cmp_err), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] code3(input logic lt,
                                       input logic eq);
    return lt ? 3'b001 : (eq ? 3'b010 : 3'b100);
  endfunction

  task automatic m_reset();
    m_redir = 1'b0;
    m_rpc   = '0;
    m_bcnt  = '0;
    m_mcnt  = '0;
  endtask

  task automatic set_op(input logic [2:0] f, input logic j,
                        input logic jr, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] r,
                        input logic t, input logic [31:0] tg);
    br_valid    = 1'b1;
    br_funct3   = f;
    br_is_jal   = j;
    br_is_jalr  = jr;
    br_pc       = p;
    br_imm      = i;
    br_rs1      = r;
    pred_taken  = t;
    pred_target = tg;
  endtask

  // One clock: drive, check ready, predict, clock, check outputs.
  task automatic tick();
    logic        is_j, slt, ult, eq, cond, bad;
    logic        tk, mis, mp, acc;
    logic [31:0] tgt;
    slt = $signed(op_a) < $signed(op_b);
    ult = op_a < op_b;
    eq  = op_a == op_b;
    cmp_result  = force_code ? fcode : code3(slt, eq);
    ucmp_result = force_code ? fcode : code3(ult, eq);
    #1;
    chk("br_ready", br_ready, !m_redir && !flush);
    acc  = br_valid && !m_redir && !flush;
    is_j = br_is_jal || br_is_jalr;
    case (br_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = slt;
      3'b101:  cond = !slt;
      3'b110:  cond = ult;
      3'b111:  cond = !ult;
      default: cond = 1'b0;
    endcase
    bad = !is_j && force_code;
    tk  = is_j || (!bad && cond);
    if (br_is_jalr) tgt = (br_rs1 + br_imm) & ~32'd1;
    else            tgt = br_pc + br_imm;
    mis = tk && tgt[1];
    mp  = !mis && (tk != pred_taken ||
                   (tk && tgt != pred_target));
    @(posedge clk);
    #1;
    if (m_redir) begin
      if (flush || redirect_ready) m_redir = 1'b0;
    end else if (acc && mp) begin
      m_redir = 1'b1;
      m_rpc   = tk ? tgt : br_pc + 32'd4;
      m_mcnt  = m_mcnt + 1;
    end
    if (acc) m_bcnt = m_bcnt + 1;
    chk("redirect_valid", redirect_valid, m_redir);
    if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    chk("link_valid", link_valid, acc && is_j && !mis);
    if (acc && is_j && !mis)
      chk("link_data", link_data, br_pc + 32'd4);
    chk("exc_valid", exc_valid, acc && mis);
    if (acc && mis) chk("exc_tval", exc_tval, tgt);
    chk("cmp_err", cmp_err, acc && bad);
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispred_cnt", mispred_cnt, m_mcnt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_br_ready"}, br_ready, 0);
    chk({tag, "_rvalid"}, redirect_valid, 0);
    chk({tag, "_rpc"}, redirect_pc, 0);
    chk({tag, "_link"}, link_valid, 0);
    chk({tag, "_ldata"}, link_data, 0);
    chk({tag, "_exc"}, exc_valid, 0);
    chk({tag, "_tval"}, exc_tval, 0);
    chk({tag, "_cerr"}, cmp_err, 0);
    chk({tag, "_bcnt"}, branch_cnt, 0);
    chk({tag, "_mcnt"}, mispred_cnt, 0);
  endtask

  initial begin
    logic [2:0]  bad_codes [5];
    logic [31:0] r, p;
    bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    rst = 1'b1; flush = 1'b0; br_valid = 1'b0;
    redirect_ready = 1'b0; force_code = 1'b0; fcode = '0;
    set_op(3'b000, 0, 0, 0, 0, 0, 0, 0);
    br_valid = 1'b0;
    op_a = 0; op_b = 0;
    cmp_result = 3'b010; ucmp_result = 3'b010;
    m_reset();
    #12;
    chk_all_zero("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // BLT taken, predicted not-taken: redirect held until ready
    op_a = 1; op_b = 2;
    set_op(3'b100, 0, 0, 32'h100, 32'h20, 0, 0, 0);
    tick();
    chk("blt_rpc", redirect_pc, 32'h120);
    chk("blt_mcnt", mispred_cnt, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("blt_hold", redirect_pc, 32'h120);
    redirect_ready = 1'b1;
    tick();
    chk("blt_clr", redirect_valid, 0);
    redirect_ready = 1'b0;

    // signed vs unsigned selection
    op_a = 1; op_b = 32'hFFFF_FFFF;
    set_op(3'b111, 0, 0, 32'h200, 32'h40, 0, 0, 0);
    tick();
    chk("bgeu_nt", redirect_valid, 0);
    set_op(3'b101, 0, 0, 32'h200, 32'h40, 0, 0, 0);
    tick();
    chk("bge_rpc", redirect_pc, 32'h240);
    br_valid = 1'b0; redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // JALR link, then misaligned JALR
    set_op(3'b000, 0, 1, 32'h300, 0, 32'h1001, 1, 32'h1000);
    tick();
    chk("jalr_link", link_data, 32'h304);
    set_op(3'b000, 0, 1, 32'h300, 0, 32'h1006, 1, 32'h1006);
    tick();
    chk("jalr_tval", exc_tval, 32'h1006);

    // back-to-back well predicted BEQ
    op_a = 7; op_b = 7;
    for (int k = 0; k < 4; k++) begin
      set_op(3'b000, 0, 0, 32'h400 + k * 4, 32'h10, 0, 1,
             32'h410 + k * 4);
      tick();
    end

    // flush kills a pending redirect; op during it not accepted
    set_op(3'b000, 0, 0, 32'h500, 32'h8, 0, 0, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // BNE with a non-one-hot code
    force_code = 1'b1; fcode = 3'b011;
    set_op(3'b001, 0, 0, 32'h600, 32'h8, 0, 1, 32'h608);
    tick();
    force_code = 1'b0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      p = $urandom & ~32'd3;
      set_op(r[2:0], r[5:3] == 0, r[5:3] == 1 || r[5:3] == 2,
             p, 32'($urandom_range(0, 8191)) - 32'd4096,
             $urandom, r[6], 0);
      if (r[5:3] == 2) br_is_jal = 1'b1;
      br_valid = r[8:7] != 0;
      op_a = $urandom;
      op_b = r[10:9] == 0 ? op_a : $urandom;
      force_code = r[14:11] == 0;
      fcode = bad_codes[r[17:15] % 5];
      if (br_is_jalr) pred_target = (br_rs1 + br_imm) & ~32'd1;
      else            pred_target = br_pc + br_imm;
      if (r[18]) pred_target = $urandom;
      flush = r[22:19] == 0;
      redirect_ready = r[24:23] == 0;
      tick();
    end
    flush = 1'b0; force_code = 1'b0; redirect_ready = 1'b0;

    // async reset while a redirect is pending
    op_a = 1; op_b = 2;
    set_op(3'b100, 0, 0, 32'h700, 32'h20, 0, 0, 0);
    tick();
    chk("pre_rst", redirect_valid, 1);
    br_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    m_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch resolution unit, directly downstream of the signed/unsigned comparator.
- Consumes the comparator's 3-bit one-hot codes plus the branch/jump operands, and decides the actual direction and target.
- Checks the fetch prediction and issues a registered redirect to fetch through a valid/ready handshake. Also produces jump link data, a misaligned-target exception, and performance counters.

Parameters:
- CNT_W, 32, width of the branch and mispredict counters.
- SUPPORT_C, 0: if 1, a 2-byte-aligned target is legal; if 0, target[1] set raises a misaligned exception.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  pipeline flush (trap/external); kills any pending redirect.
- br_valid  input  1  branch/jump op presented.
- br_ready  output  1  unit can accept an op this cycle.
- br_funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- br_is_jal  input  1  JAL (unconditional).
- br_is_jalr  input  1  JALR (unconditional).
- br_pc  input  32  PC of the op.
- br_imm  input  32  sign-extended offset.
- br_rs1  input  32  rs1 value (JALR base).
- cmp_result  input  3  signed compare: 001 = rs1 < rs2, 010 = equal, 100 = rs1 > rs2.
- ucmp_result  input  3  unsigned compare, same encoding.
- pred_taken  input  1  fetch prediction.
- pred_target  input  32  predicted target.
- redirect_valid  output  1  fetch redirect pending.
- redirect_ready  input  1  fetch accepts the redirect.
- redirect_pc  output  32  corrected fetch PC.
- link_valid  output  1  one-cycle pulse: link data valid (JAL/JALR).
- link_data  output  32  pc+4 for rd writeback.
- exc_valid  output  1  one-cycle pulse: misaligned-target exception.
- exc_tval  output  32  offending target.
- cmp_err  output  1  one-cycle pulse: comparator code not one-hot on a conditional branch.
- branch_cnt  output  CNT_W  count of resolved ops.
- mispred_cnt  output  CNT_W  count of redirects issued.

Behaviour:
- Reset (async, rst=1): every output = 0; counters = 0; no redirect pending.
- Accept condition: br_valid && br_ready.
- br_ready = !redirect_valid && !flush. It is therefore low during the redirect handshake cycle, so a younger op is never accepted alongside the redirect.
- Code selection: signed ops (BLT/BGE/BEQ/BNE) use cmp_result; BLTU/BGEU use ucmp_result.
- Conditions: BEQ on 010; BNE on 001|100; BLT/BLTU on 001; BGE/BGEU on 010|100.
- JAL/JALR are always taken; if both flags are set, JALR wins.
- Undefined funct3 (010, 011) on a conditional branch: not taken.
- Non-one-hot compare code on a conditional branch: not taken, and cmp_err pulses.
- Targets, all mod 2^32:
  - branch/JAL: pc + imm.
  - JALR: (rs1 + imm) & ~1.
- Misaligned: taken && target[1] && !SUPPORT_C. Result: exc_valid=1 and exc_tval=target at T+1; no redirect and no link_valid for that op.
- Mispredict: actual_taken != pred_taken, or (actual_taken && target != pred_target).
  - redirect_pc = taken ? target : pc+4.
  - redirect_valid and redirect_pc are registered at T+1 and held stable until the cycle redirect_ready=1; that handshake cycle clears them.
- link_valid / link_data: pulse at T+1 for JAL/JALR, independent of mispredict.
- Counters (wrap at 2^CNT_W):
  - branch_cnt +1 at T+1 per accepted op, including misaligned ones.
  - mispred_cnt +1 when a redirect is set.
- Flush handling:
  - flush=1 clears redirect_valid next cycle, with no handshake.
  - An op accepted the cycle before flush still produces its pulses at T+1.
  - flush has priority over redirect_ready.
- States: IDLE (accepting), REDIRECT (redirect_valid=1, stalled).
  - IDLE→REDIRECT on accept with mispredict and no misalign.
  - REDIRECT→IDLE on redirect_ready or flush.
- Throughput: one op per cycle when there is no mispredict.

Test Plan:
- BLT, cmp_result=001, pc=0x100, imm=0x20, pred_taken=0 → T+1: redirect_valid=1, redirect_pc=0x120, mispred_cnt=1. Hold redirect_ready=0 for 3 cycles → redirect stays stable and br_ready=0. Raise redirect_ready → cleared next cycle.
- BGEU, ucmp_result=001, cmp_result=100, pred_taken=0 → not taken, no redirect, branch_cnt=1. Same inputs with funct3=101 (BGE) → taken, redirect to pc+imm.
- JALR, rs1=0x1003, imm=0, pred_taken=1, pred_target=0x1002 → target 0x1002, no redirect, link_valid=1, link_data=pc+4. Same op with rs1=0x1006, SUPPORT_C=0 → exc_valid=1, exc_tval=0x1006, no link/redirect.
- Back-to-back correctly-predicted BEQ ops (cmp_result=010) for 4 cycles → br_ready stays 1, branch_cnt=4, mispred_cnt=0.
- Redirect pending and flush=1 with redirect_ready=0 → redirect_valid=0 next cycle; br_valid asserted during the handshake cycle is not accepted (br_ready=0).
- BNE with cmp_result=011 → cmp_err pulse, not taken. Assert rst mid-REDIRECT → all outputs 0 immediately, counters 0.
